// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: default data width,
// FSM state encoding and a saturating increment used by statistics counters.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  // Working width of sat_inc; callers cast their counters to and from it.
  localparam int SAT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_STALL = 2'd2
  } fsm_state_t;

  // Increment val by one unless it already sits at max_val.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_stream_adapter_if.sv
// Producer stream plus FIFO write port of the write-side adapter.
// master: the side that produces words and reports FIFO full.
// slave:  the adapter itself.
interface fifo_wr_stream_adapter_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (
    output in_valid,
    output in_data,
    output fifo_full,
    input  in_ready,
    input  fifo_wr_en,
    input  fifo_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  fifo_full,
    output in_ready,
    output fifo_wr_en,
    output fifo_data
  );

endinterface

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready skid buffer. in_ready depends on registered
// occupancy only, so nothing downstream reaches the producer's ready
// combinationally. The caller must only assert pop while count != 0.
module skid_buffer2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count,
  output logic [1:0]            count_nxt
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  push;

  assign in_ready  = !rstb && (count_q != 2'd2);
  assign push      = in_valid && in_ready;
  assign head_data = mem_q[head_q];
  assign count     = count_q;
  assign count_nxt = count_d;

  // Next-state: write at tail on push, advance head on pop, track occupancy.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = in_data;
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // Buffer state register; reset empties the buffer and zeroes both entries.
  always_ff @(posedge clka) begin
    if (rstb) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fifo_wr_stream_adapter.sv
// Write-side front end for the dual-clock FIFO (clka domain). Buffers the
// producer stream in a 2-entry skid buffer, writes the FIFO only while it is
// not full, and keeps saturating write/stall counters plus a sticky
// stall-timeout flag.
module fifo_wr_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_LIMIT = 16
) (
  input  logic                       clka,
  input  logic                       rstb,
  fifo_wr_stream_adapter_if.slave    bus,
  input  logic                       clear_stats,
  output logic [CNT_WIDTH-1:0]       wr_count,
  output logic [CNT_WIDTH-1:0]       stall_count,
  output logic                       stall_timeout,
  output logic                       busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] LIMIT_CNT = CNT_WIDTH'(STALL_LIMIT);

  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            count;
  logic [1:0]            count_nxt;
  logic                  pop;
  logic                  stall_cond;

  fsm_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0]  stall_run_q, stall_run_d;
  logic                  stall_timeout_q, stall_timeout_d;

  skid_buffer2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clka      (clka),
    .rstb      (rstb),
    .in_valid  (bus.in_valid),
    .in_data   (bus.in_data),
    .in_ready  (bus.in_ready),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .count_nxt (count_nxt)
  );

  // The full flag gates the write strobe in the same cycle; it never feeds in_ready.
  assign pop            = !rstb && (count != 2'd0) && !bus.fifo_full;
  assign stall_cond     = !rstb && (count != 2'd0) && bus.fifo_full;
  assign bus.fifo_wr_en = pop;
  assign bus.fifo_data  = rstb ? '0 : head_data;

  // State tracks registered occupancy, so IDLE means the buffer is empty.
  assign busy           = !rstb && (state_q != S_IDLE);

  assign wr_count       = wr_count_q;
  assign stall_count    = stall_count_q;
  assign stall_timeout  = stall_timeout_q;

  // FSM next state from next-cycle occupancy and the current full flag.
  always_comb begin
    state_d = S_IDLE;
    if (count_nxt != 2'd0) begin
      state_d = bus.fifo_full ? S_STALL : S_XFER;
    end
  end

  // Statistics next state; clear_stats overrides any increment or set.
  always_comb begin
    wr_count_d      = wr_count_q;
    stall_count_d   = stall_count_q;
    stall_run_d     = stall_run_q;
    stall_timeout_d = stall_timeout_q;
    if (clear_stats) begin
      wr_count_d      = '0;
      stall_count_d   = '0;
      stall_run_d     = '0;
      stall_timeout_d = 1'b0;
    end else begin
      if (pop) begin
        wr_count_d = CNT_WIDTH'(sat_inc(SAT_W'(wr_count_q), SAT_W'(CNT_MAX)));
      end
      if (stall_cond) begin
        stall_count_d = CNT_WIDTH'(sat_inc(SAT_W'(stall_count_q), SAT_W'(CNT_MAX)));
        stall_run_d   = CNT_WIDTH'(sat_inc(SAT_W'(stall_run_q), SAT_W'(CNT_MAX)));
      end else begin
        stall_run_d   = '0;
      end
      if (stall_cond && (stall_run_d == LIMIT_CNT)) begin
        stall_timeout_d = 1'b1;
      end
    end
  end

  // FSM and statistics registers.
  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q         <= S_IDLE;
      wr_count_q      <= '0;
      stall_count_q   <= '0;
      stall_run_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_count_q      <= wr_count_d;
      stall_count_q   <= stall_count_d;
      stall_run_q     <= stall_run_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_stream_adapter.sv
// Self-checking bench for fifo_wr_stream_adapter: a queue-based model of the
// adapter is compared against the DUT every cycle, with literal expectations
// for the directed scenarios.
module tb_fifo_wr_stream_adapter;

  localparam int DW        = 8;
  localparam int CW        = 16;
  localparam int LIMIT     = 16;
  localparam int CNT_MAX_I = 65535;

  logic          clka = 1'b0;
  logic          rstb;
  logic          clear_stats;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] stall_count;
  logic          stall_timeout;
  logic          busy;

  fifo_wr_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

  fifo_wr_stream_adapter #(
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .STALL_LIMIT (LIMIT)
  ) dut (
    .clka          (clka),
    .rstb          (rstb),
    .bus           (bus),
    .clear_stats   (clear_stats),
    .wr_count      (wr_count),
    .stall_count   (stall_count),
    .stall_timeout (stall_timeout),
    .busy          (busy)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  // Behavioural model: contents of the adapter as a plain queue plus counters.
  logic [DW-1:0] m_q [$];
  int            m_wr, m_stall, m_consec;
  logic          m_to;

  // Words seen on the FIFO write port, and write-burst tracking.
  logic [DW-1:0] dut_log [$];
  int            run_len, max_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the inputs that were present.
  task automatic model_step();
    logic m_pop, m_push, m_stl;
    if (rstb) begin
      m_q.delete();
      m_wr = 0; m_stall = 0; m_consec = 0; m_to = 1'b0;
    end else begin
      m_pop  = (m_q.size() > 0) && !bus.fifo_full;
      m_stl  = (m_q.size() > 0) && bus.fifo_full;
      m_push = bus.in_valid && (m_q.size() < 2);
      if (m_pop)  void'(m_q.pop_front());
      if (m_push) m_q.push_back(bus.in_data);
      if (clear_stats) begin
        m_wr = 0; m_stall = 0; m_consec = 0; m_to = 1'b0;
      end else begin
        if (m_pop && m_wr < CNT_MAX_I) m_wr++;
        if (m_stl && m_stall < CNT_MAX_I) m_stall++;
        if (m_stl) begin
          if (m_consec < CNT_MAX_I) m_consec++;
        end else begin
          m_consec = 0;
        end
        if (m_stl && m_consec == LIMIT) m_to = 1'b1;
      end
    end
  endtask

  // Compare all DUT outputs against the model in the middle of each cycle.
  task automatic compare_outputs();
    if (rstb) begin
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_wr_en", bus.fifo_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fifo_data", bus.fifo_data, 0);
    end else begin
      chk("in_ready", bus.in_ready, m_q.size() < 2);
      chk("wr_en", bus.fifo_wr_en, (m_q.size() > 0) && !bus.fifo_full);
      chk("busy", busy, m_q.size() > 0);
      if (m_q.size() > 0) chk("fifo_data", bus.fifo_data, m_q[0]);
      chk("wr_count", wr_count, m_wr);
      chk("stall_count", stall_count, m_stall);
      chk("stall_timeout", stall_timeout, m_to);
    end
    if (bus.fifo_wr_en === 1'b1) begin
      dut_log.push_back(bus.fifo_data);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  always @(negedge clka) compare_outputs();

  // One clock cycle with the given inputs; acc reports a handshake at the edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic f,
                     input logic c, output logic acc);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.fifo_full = f;
    clear_stats   = c;
    #1;
    acc = v && bus.in_ready;
    @(posedge clka);
    model_step();
    #1;
  endtask

  task automatic drain();
    logic acc;
    int   budget = 0;
    while (busy && budget < 200) begin
      cyc(1'b0, '0, 1'b0, 1'b0, acc);
      budget++;
    end
    chk("drain_done", busy, 0);
  endtask

  // Offer n consecutive words base.. ; mode 0 full low, 1 full toggling.
  task automatic stream(input logic [DW-1:0] base, input int n, input int mode);
    logic acc, f;
    int   idx = 0;
    int   budget = 0;
    while (idx < n && budget < 2000) begin
      f = (mode == 1) ? budget[0] : 1'b0;
      cyc(1'b1, DW'(base + idx), f, 1'b0, acc);
      if (acc) idx++;
      budget++;
    end
    chk("stream_accepted", idx, n);
    drain();
  endtask

  task automatic check_log(input string name, input logic [DW-1:0] base, input int n);
    chk({name, "_len"}, dut_log.size(), n);
    for (int i = 0; i < n && i < dut_log.size(); i++) begin
      chk({name, "_word"}, dut_log[i], DW'(base + i));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n_acc;
    rstb = 1'b1; clear_stats = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.fifo_full = 1'b0;
    m_wr = 0; m_stall = 0; m_consec = 0; m_to = 1'b0;
    run_len = 0; max_run = 0;

    // Reset
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, acc);
    rstb = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_wr_count", wr_count, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_data", bus.fifo_data, 0);

    // Stream 0x01..0x10 with the FIFO never full
    dut_log.delete(); max_run = 0;
    stream(8'h01, 16, 0);
    check_log("t1", 8'h01, 16);
    chk("t1_wr_count", wr_count, 16);
    chk("t1_burst", max_run, 16);

    // FIFO full: only two words fit, nothing is written until full drops
    dut_log.delete();
    cyc(1'b1, 8'hA0, 1'b1, 1'b0, acc); chk("t2_acc0", acc, 1);
    cyc(1'b1, 8'hA1, 1'b1, 1'b0, acc); chk("t2_acc1", acc, 1);
    chk("t2_ready_low", bus.in_ready, 0);
    chk("t2_busy", busy, 1);
    cyc(1'b1, 8'hA2, 1'b1, 1'b0, acc); chk("t2_acc2_blocked", acc, 0);
    chk("t2_wr_en_low", bus.fifo_wr_en, 0);
    for (int i = 0; i < 10 && !acc; i++) cyc(1'b1, 8'hA2, 1'b0, 1'b0, acc);
    chk("t2_acc2", acc, 1);
    drain();
    check_log("t2", 8'hA0, 3);

    // Sustained stall reaches the timeout on the 16th stall edge
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    dut_log.delete();
    cyc(1'b1, 8'h55, 1'b1, 1'b0, acc);
    for (int i = 0; i < LIMIT - 1; i++) cyc(1'b0, '0, 1'b1, 1'b0, acc);
    chk("t3_timeout_before", stall_timeout, 0);
    chk("t3_stall_15", stall_count, 15);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    chk("t3_timeout_set", stall_timeout, 1);
    chk("t3_stall_16", stall_count, 16);
    drain();
    chk("t3_timeout_sticky", stall_timeout, 1);
    check_log("t3", 8'h55, 1);

    // Full toggling every cycle while streaming 0x00..0x3F
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    chk("t4_cleared", stall_timeout, 0);
    dut_log.delete();
    stream(8'h00, 64, 1);
    check_log("t4", 8'h00, 64);
    chk("t4_wr_count", wr_count, 64);
    chk("t4_timeout", stall_timeout, 0);

    // Reset with two words buffered behind a full FIFO
    dut_log.delete();
    cyc(1'b1, 8'h77, 1'b1, 1'b0, acc);
    cyc(1'b1, 8'h78, 1'b1, 1'b0, acc);
    chk("t5_busy_before", busy, 1);
    rstb = 1'b1;
    bus.in_valid = 1'b0; bus.fifo_full = 1'b0;
    #1;
    chk("t5_wr_en_in_rst", bus.fifo_wr_en, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t5_busy_after", busy, 0);
    chk("t5_ready_in_rst", bus.in_ready, 0);
    rstb = 1'b0;
    #1;
    chk("t5_wr_count", wr_count, 0);
    chk("t5_stall_count", stall_count, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t5_nothing_written", dut_log.size(), 0);

    // clear_stats on the same edge as a write wins
    cyc(1'b1, 8'h11, 1'b0, 1'b0, acc);
    chk("t6_wr_en", bus.fifo_wr_en, 1);
    cyc(1'b1, 8'h22, 1'b0, 1'b1, acc);
    chk("t6_cleared", wr_count, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t6_after_write", wr_count, 1);
    drain();

    // Randomised traffic against the model
    dut_log.delete();
    cyc(1'b0, '0, 1'b0, 1'b1, acc);
    n_acc = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) == 0,
          ($urandom % 60) == 0, acc);
      if (acc) n_acc++;
    end
    drain();
    chk("rand_no_loss", dut_log.size(), n_acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_stream_adapter.md
Name: fifo_wr_stream_adapter

Overview:
- Write-side front end for the team's dual-clock FIFO, running entirely in the clka domain.
- Accepts a valid/ready producer stream and buffers it in a 2-entry skid buffer.
- Drives the FIFO write port (data, wr_en) strictly gated by the FIFO full flag, so no write is ever issued into a full FIFO.
- Breaks the combinational path from FIFO full to producer ready, and keeps write/stall statistics plus a sticky stall-timeout flag.

Parameters:
- DATA_WIDTH, 8, width of the stream and FIFO data words.
- CNT_WIDTH, 16, width of the saturating statistics counters.
- STALL_LIMIT, 16, number of consecutive stall cycles that sets stall_timeout; must be at least 1 and at most 2^CNT_WIDTH-1.

Ports:
- clka  in  1  write-domain clock; all logic is on its rising edge.
- rstb  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer word valid.
- in_data  in  DATA_WIDTH  producer word.
- in_ready  out  1  adapter can accept a word this cycle.
- fifo_full  in  1  full flag from the FIFO write side.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_data  out  DATA_WIDTH  FIFO write data.
- clear_stats  in  1  synchronous clear of counters and stall_timeout.
- wr_count  out  CNT_WIDTH  words written to the FIFO, saturating.
- stall_count  out  CNT_WIDTH  cycles spent in STALL, saturating.
- stall_timeout  out  1  sticky: consecutive stall reached STALL_LIMIT.
- busy  out  1  skid buffer non-empty.

Behaviour:
- Reset (rstb=1 at a clka edge):
  - occupancy count=0 and FSM=IDLE.
  - wr_count, stall_count, stall_timeout, the consecutive-stall counter and both skid entries are cleared to 0.
  - While rstb is high: in_ready=0, fifo_wr_en=0, busy=0, fifo_data=0.
- Skid buffer: two entries, head/tail, occupancy count 0..2.
  - in_ready = !rstb && (count != 2). It is a function of registered state only and never of fifo_full or in_valid.
- Push: in_valid && in_ready at an edge. The word is stored at the tail.
- Pop:
  - fifo_wr_en = (count != 0) && !fifo_full, combinational.
  - fifo_data = head entry, and is held stable while count != 0 and no pop occurs.
  - When count == 0, fifo_data shows the last head value; it is don't-care but deterministic, and is 0 after reset.
- Pop happens when fifo_wr_en=1 at an edge; the head then advances.
- Simultaneous push and pop: count is unchanged. Sustained throughput is 1 word/cycle.
- Latency: a word accepted at edge N appears on fifo_data and is eligible for fifo_wr_en in the cycle after edge N. Minimum 1 cycle input-to-write.
- Ordering is strict FIFO. No word is dropped or duplicated.
- FSM, updated every edge from next-state occupancy and the current fifo_full:
  - IDLE: count==0.
  - XFER: count>0 && !fifo_full.
  - STALL: count>0 && fifo_full.
  - Transitions follow directly from these conditions each cycle.
  - busy = (count != 0).
- Counters:
  - wr_count increments by 1 on every fifo_wr_en edge and saturates at all-ones.
  - stall_count increments on every edge where count>0 && fifo_full, and saturates.
  - The consecutive-stall counter increments under the same condition and clears on any cycle without that condition.
  - When the consecutive-stall counter reaches STALL_LIMIT, stall_timeout is set to 1. It stays set until rstb or clear_stats.
- clear_stats: zeroes wr_count, stall_count, the consecutive-stall counter and stall_timeout on that edge.
  - clear wins over a simultaneous increment or set.
  - clear does not affect buffer contents or the FSM.
- fifo_full asserting or deasserting at any cycle is legal. The adapter reacts in the same cycle through the combinational wr_en gate.
- Reset mid-stream discards buffered words without writing them.

Decomposition:
- Shared package (fifo_pkg) holds:
  - DATA_WIDTH default.
  - The FSM state encoding constants S_IDLE=2'd0, S_XFER=2'd1, S_STALL=2'd2.
  - A saturating-increment function reused by other statistics blocks.
- One natural sub-module: skid_buffer2, the 2-entry valid/ready buffer with count, head/tail and in_ready. It is instantiated once.
- The top level adds the fifo_full gating, FSM and counters.

Test Plan:
- Reset then stream 0x01..0x10 with in_valid held and fifo_full=0 -> in_ready stays 1, fifo_wr_en high for 16 consecutive cycles starting 1 cycle after the first accept, data in order, wr_count=16.
- Hold fifo_full=1 and offer 0xA0,0xA1,0xA2 -> first two accepted, in_ready=0 after the second, fifo_wr_en=0, FSM=STALL; release full -> 0xA0,0xA1,0xA2 written in order, no loss.
- fifo_full=1 with count>0 for 16 cycles (STALL_LIMIT=16) -> stall_timeout rises on the 16th stall edge and stays 1 after full drops; stall_count=16.
- Toggle fifo_full every cycle while streaming 0x00..0x3F -> all 64 words written exactly once in order, wr_count=64, stall_timeout stays 0.
- Assert rstb with 2 words buffered and fifo_full=1 -> next cycle busy=0, in_ready=0 during reset, counters 0, buffered words never written.
- Pulse clear_stats on the same edge as a write -> wr_count=0 afterwards (clear wins); the subsequent write increments it to 1.
